ahb_lite_bus_arbiter: RTL and testbench
=======================================

// Module: ahb_lite_bus_arbiter
// PURPOSE
//  Round-robin, burst-aware arbiter sharing one AHB-Lite slave port among NUM_MASTERS requesters.
//  Produces a one-hot address-phase grant, the address-phase owner index (drives the master-side mux)
//  and a registered data-phase owner index (routes HRDATA/HRESP back). Sits between the master
//  agents and the AHB-Lite interconnect; the owner's HTRANS/HBURST are fed back from the mux output.
// PARAMETERS
//  NUM_MASTERS  4  number of requesters (2..16)
//  PARK_MASTER  0  master granted when no request is pending
//  MW  $clog2(NUM_MASTERS)  index width (derived localparam, not overridable)
// PORTS
//  hclk            in   1            bus clock, all state on rising edge
//  hresetn         in   1            synchronous active-low reset
//  hreq_i          in   NUM_MASTERS  bus request per master
//  hlock_i         in   NUM_MASTERS  locked-transfer request per master
//  htrans_i        in   2            HTRANS of current address-phase owner (IDLE=0,BUSY=1,NONSEQ=2,SEQ=3)
//  hburst_i        in   3            HBURST of current owner (SINGLE=0,INCR=1,WRAP4..INCR16=2..7)
//  hready_i        in   1            bus HREADY (transfer completes when 1)
//  hgrant_o        out  NUM_MASTERS  one-hot address-phase grant
//  hmaster_o       out  MW           address-phase owner index
//  hmaster_data_o  out  MW           data-phase owner index
//  hmastlock_o     out  1            HMASTLOCK for current address phase
// BEHAVIOUR
//  Reset (hresetn=0 at posedge): state=ARB, hgrant_o=1<<PARK_MASTER, hmaster_o=hmaster_data_o=PARK_MASTER,
//   hmastlock_o=0, beat_cnt=0, rr_last=PARK_MASTER. Reset mid-burst aborts it; no state survives.
//  All outputs registered. Nothing changes while hready_i=0 (wait states freeze FSM, counter, grant).
//  FSM states: ARB, BURST, LOCKED.
//  ARB, hready_i=1:
//   - if hlock_i[owner]&hreq_i[owner]: stay with owner, hmastlock_o<=1, ->LOCKED.
//   - else if owner drives NONSEQ with hburst_i fixed length L (4/8/16): keep grant, beat_cnt<=L-1, ->BURST.
//   - else if owner drives NONSEQ with hburst_i=INCR: keep grant, ->BURST (undefined length).
//   - else arbitrate: next owner = first set hreq_i scanning rr_last+1, +2, ... wrapping mod NUM_MASTERS;
//     none set -> PARK_MASTER. Grant, hmaster_o, rr_last update next posedge (req->grant latency 1 clk).
//  BURST, hready_i=1:
//   - SEQ: fixed burst beat_cnt-=1; at beat_cnt reaching 0 (last SEQ accepted) ->ARB.
//   - BUSY: no decrement, stay.
//   - IDLE or NONSEQ (early termination, incl. after ERROR): ->ARB, beat_cnt<=0; this same cycle is
//     treated as an ARB cycle (NONSEQ may open a new burst only if owner re-wins arbitration).
//   - INCR: stay while hreq_i[owner]=1; owner dropping hreq_i ->ARB on that cycle.
//  LOCKED, hready_i=1: hold grant; exit to ARB when hlock_i[owner]=0 and htrans_i=IDLE; hmastlock_o<=0 then.
//  Data phase: hmaster_data_o <= hmaster_o on every posedge with hready_i=1; else holds.
//  Grant never changes while hready_i=0 or mid fixed burst/lock, regardless of other requests.
//  hgrant_o always exactly one-hot; hmaster_o always equals its index.
//  Fixed-burst counter 4 bits; hburst WRAPx and INCRx with same x give same L.
//  Owner with hreq_i=0 in ARB loses grant to any requester; if none, parks (even if parked=owner).
// TESTING
//  1 Reset: hold hresetn=0 3 clks with hreq_i=4'b1111 -> hgrant_o=4'b0001, hmaster_o=0, hmastlock_o=0.
//  2 Round-robin: hreq_i=4'b1111, owner drives SINGLE NONSEQ each cycle, hready_i=1 -> hmaster_o 1,2,3,0,1...
//  3 Fixed burst: M2 NONSEQ INCR4 then 3 SEQ with one BUSY and 2 wait states, M1 requesting throughout
//    -> grant stays M2 until last SEQ accepted, M1 granted next clk; hmaster_data_o lags hmaster_o by one accepted beat.
//  4 Early termination: M3 WRAP8, IDLE after 2 SEQ, hreq_i=4'b0011 -> ->ARB, grant to M0 next clk.
//  5 Lock: M1 hlock_i=1 for 5 transfers, others requesting -> hmastlock_o=1, grant M1 throughout;
//    lock drop + IDLE -> hmastlock_o=0, grant rotates to M2.
//  6 Park / reset mid-burst: hreq_i=0 -> hgrant_o=4'b0001; assert hresetn=0 mid INCR16 on M2 -> ARB, grant M0 next clk.

Source files
------------

// File: rtl/ahb_lite_bus_arbiter_if.sv
// ahb_lite_bus_arbiter_if
//   Bundles the arbiter's request/transfer-status inputs and its grant/owner
//   outputs so that requesters and the arbiter share one connection.
//   Signal names keep their _i/_o suffixes as seen from the arbiter.
//
//   slave  modport : the arbiter's view (requests in, grant/owner out)
//   master modport : the requester/interconnect view (requests out, grant in)
//
//   hreq_i          per-master bus request
//   hlock_i         per-master locked-transfer request
//   htrans_i        HTRANS of the current address-phase owner
//   hburst_i        HBURST of the current address-phase owner
//   hready_i        bus HREADY
//   hgrant_o        one-hot address-phase grant
//   hmaster_o       address-phase owner index
//   hmaster_data_o  data-phase owner index
//   hmastlock_o     HMASTLOCK for the current address phase
interface ahb_lite_bus_arbiter_if #(
  parameter int NUM_MASTERS = 4
) ();
  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [NUM_MASTERS-1:0] hreq_i;
  logic [NUM_MASTERS-1:0] hlock_i;
  logic [1:0]             htrans_i;
  logic [2:0]             hburst_i;
  logic                   hready_i;
  logic [NUM_MASTERS-1:0] hgrant_o;
  logic [MW-1:0]          hmaster_o;
  logic [MW-1:0]          hmaster_data_o;
  logic                   hmastlock_o;

  modport slave (
    input  hreq_i, hlock_i, htrans_i, hburst_i, hready_i,
    output hgrant_o, hmaster_o, hmaster_data_o, hmastlock_o
  );

  modport master (
    output hreq_i, hlock_i, htrans_i, hburst_i, hready_i,
    input  hgrant_o, hmaster_o, hmaster_data_o, hmastlock_o
  );
endinterface

// File: rtl/ahb_lite_bus_arbiter.sv
// ahb_lite_bus_arbiter
//   Round-robin, burst-aware arbiter sharing one AHB-Lite slave port among
//   NUM_MASTERS requesters. Fixed-length bursts and locked sequences keep the
//   grant; otherwise the next requester after the last winner gets the bus.
//   All outputs are registered; HREADY low freezes every piece of state.
//
//   hclk     bus clock, all state on the rising edge
//   hresetn  synchronous active-low reset
//   bus      ahb_lite_bus_arbiter_if.slave (requests/status in, grant out)
module ahb_lite_bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int PARK_MASTER = 0
) (
  input logic                   hclk,
  input logic                   hresetn,
  ahb_lite_bus_arbiter_if.slave bus
);
  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;
  localparam logic [2:0] HBURST_INCR   = 3'd1;

  typedef enum logic [1:0] {ARB, BURST, LOCKED} state_t;

  state_t                 state_reg, state_next;
  logic [3:0]             beat_reg, beat_next;
  logic [MW-1:0]          owner_reg, owner_next;
  logic [MW-1:0]          data_owner_reg, data_owner_next;
  logic [MW-1:0]          rr_last_reg, rr_last_next;
  logic                   lock_reg, lock_next;
  logic                   burst_incr_reg, burst_incr_next;
  logic [NUM_MASTERS-1:0] grant_reg, grant_next;
  logic [MW-1:0]          winner;
  logic                   arb_cycle;
  logic                   rearb;

  // Remaining SEQ beats after the NONSEQ of a fixed burst (WRAPx == INCRx).
  function automatic logic [3:0] burst_remaining(input logic [2:0] hb);
    case (hb)
      3'd2, 3'd3: burst_remaining = 4'd3;
      3'd4, 3'd5: burst_remaining = 4'd7;
      3'd6, 3'd7: burst_remaining = 4'd15;
      default:    burst_remaining = 4'd0;
    endcase
  endfunction

  // Round-robin search starting just after the last winner; the last winner
  // itself is checked last so it only keeps the bus if nobody else asks.
  always_comb begin
    int idx;
    logic found;
    idx    = 0;
    found  = 1'b0;
    winner = MW'(PARK_MASTER);
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx = (int'(rr_last_reg) + i) % NUM_MASTERS;
      if (!found && bus.hreq_i[idx]) begin
        winner = idx[MW-1:0];
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    beat_next       = beat_reg;
    owner_next      = owner_reg;
    data_owner_next = data_owner_reg;
    rr_last_next    = rr_last_reg;
    lock_next       = lock_reg;
    burst_incr_next = burst_incr_reg;
    arb_cycle       = 1'b0;
    rearb           = 1'b0;

    if (bus.hready_i) begin
      data_owner_next = owner_reg;
      case (state_reg)
        ARB: arb_cycle = 1'b1;
        BURST: begin
          if (bus.htrans_i == HTRANS_IDLE || bus.htrans_i == HTRANS_NONSEQ) begin
            // Early termination: this cycle arbitrates like ARB, but a new
            // burst is only opened if the owner wins again.
            arb_cycle = 1'b1;
            rearb     = 1'b1;
            beat_next = 4'd0;
          end else if (burst_incr_reg) begin
            if (!bus.hreq_i[owner_reg]) begin
              arb_cycle = 1'b1;
            end
          end else if (bus.htrans_i == HTRANS_SEQ) begin
            beat_next = beat_reg - 4'd1;
            if (beat_reg == 4'd1) begin
              state_next = ARB;
            end
          end
        end
        LOCKED: begin
          if (!bus.hlock_i[owner_reg] && bus.htrans_i == HTRANS_IDLE) begin
            state_next = ARB;
            lock_next  = 1'b0;
          end
        end
        default: state_next = ARB;
      endcase

      if (arb_cycle) begin
        state_next      = ARB;
        burst_incr_next = 1'b0;
        if (rearb && winner != owner_reg) begin
          owner_next   = winner;
          rr_last_next = winner;
        end else if (bus.hlock_i[owner_reg] && bus.hreq_i[owner_reg]) begin
          state_next = LOCKED;
          lock_next  = 1'b1;
        end else if (bus.htrans_i == HTRANS_NONSEQ && bus.hburst_i > HBURST_INCR) begin
          state_next = BURST;
          beat_next  = burst_remaining(bus.hburst_i);
        end else if (bus.htrans_i == HTRANS_NONSEQ && bus.hburst_i == HBURST_INCR) begin
          state_next      = BURST;
          burst_incr_next = 1'b1;
        end else begin
          owner_next   = winner;
          rr_last_next = winner;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_grant
    assign grant_next[gi] = (owner_next == MW'(gi));
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_reg      <= ARB;
      beat_reg       <= 4'd0;
      owner_reg      <= MW'(PARK_MASTER);
      data_owner_reg <= MW'(PARK_MASTER);
      rr_last_reg    <= MW'(PARK_MASTER);
      lock_reg       <= 1'b0;
      burst_incr_reg <= 1'b0;
      grant_reg      <= NUM_MASTERS'(1) << PARK_MASTER;
    end else begin
      state_reg      <= state_next;
      beat_reg       <= beat_next;
      owner_reg      <= owner_next;
      data_owner_reg <= data_owner_next;
      rr_last_reg    <= rr_last_next;
      lock_reg       <= lock_next;
      burst_incr_reg <= burst_incr_next;
      grant_reg      <= grant_next;
    end
  end

  assign bus.hgrant_o       = grant_reg;
  assign bus.hmaster_o      = owner_reg;
  assign bus.hmaster_data_o = data_owner_reg;
  assign bus.hmastlock_o    = lock_reg;
endmodule

// File: tb/tb_ahb_lite_bus_arbiter.sv
// tb_ahb_lite_bus_arbiter
//   Directed bench for the 4-master arbiter: reset, round-robin rotation,
//   fixed burst with BUSY and wait states, early termination, locked
//   sequence, parking and reset in the middle of a burst.
module tb_ahb_lite_bus_arbiter;
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NONSEQ = 2'd2, SEQ = 2'd3;

  logic hclk;
  logic hresetn;
  int   checks;
  int   failures;

  ahb_lite_bus_arbiter_if #(.NUM_MASTERS(4)) bus ();

  ahb_lite_bus_arbiter #(
    .NUM_MASTERS(4),
    .PARK_MASTER(0)
  ) dut (
    .hclk   (hclk),
    .hresetn(hresetn),
    .bus    (bus)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive(input logic [3:0] req, input logic [3:0] lock,
                       input logic [1:0] trans, input logic [2:0] burst,
                       input logic ready);
    bus.hreq_i   = req;
    bus.hlock_i  = lock;
    bus.htrans_i = trans;
    bus.hburst_i = burst;
    bus.hready_i = ready;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    int rr_seq [5];
    int prev;
    checks   = 0;
    failures = 0;
    rr_seq   = '{1, 2, 3, 0, 1};

    // 1: reset held 3 clocks with everyone requesting
    hresetn = 1'b0;
    drive(4'b1111, 4'b0000, IDLE, 3'd0, 1'b1);
    repeat (3) tick();
    chk("reset_grant",    32'(bus.hgrant_o), 32'h1);
    chk("reset_master",   32'(bus.hmaster_o), 32'h0);
    chk("reset_data",     32'(bus.hmaster_data_o), 32'h0);
    chk("reset_mastlock", 32'(bus.hmastlock_o), 32'h0);
    hresetn = 1'b1;

    // 2: round robin with SINGLE NONSEQ transfers
    drive(4'b1111, 4'b0000, NONSEQ, 3'd0, 1'b1);
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("rr_master_%0d", k), 32'(bus.hmaster_o), 32'(rr_seq[k]));
      chk($sformatf("rr_grant_%0d", k),  32'(bus.hgrant_o), 32'(1) << rr_seq[k]);
      chk($sformatf("rr_data_%0d", k),   32'(bus.hmaster_data_o), 32'(prev));
      prev = rr_seq[k];
    end

    // 3: fixed INCR4 burst on M2 with BUSY and two wait states, M1 requesting
    drive(4'b0100, 4'b0000, IDLE, 3'd0, 1'b1);
    tick();
    chk("burst_own_m2", 32'(bus.hmaster_o), 32'h2);
    drive(4'b0110, 4'b0000, NONSEQ, 3'd3, 1'b1);
    tick();
    chk("burst_nonseq", 32'(bus.hmaster_o), 32'h2);
    drive(4'b0110, 4'b0000, SEQ, 3'd3, 1'b1);
    tick();
    chk("burst_seq1", 32'(bus.hmaster_o), 32'h2);
    drive(4'b0110, 4'b0000, BUSY, 3'd3, 1'b1);
    tick();
    chk("burst_busy", 32'(bus.hmaster_o), 32'h2);
    drive(4'b0110, 4'b0000, SEQ, 3'd3, 1'b0);
    repeat (2) tick();
    chk("burst_wait_grant", 32'(bus.hgrant_o), 32'h4);
    drive(4'b0110, 4'b0000, SEQ, 3'd3, 1'b1);
    tick();
    chk("burst_seq2", 32'(bus.hmaster_o), 32'h2);
    tick();
    chk("burst_seq3_last", 32'(bus.hmaster_o), 32'h2);
    drive(4'b0010, 4'b0000, IDLE, 3'd0, 1'b1);
    tick();
    chk("burst_m1_grant", 32'(bus.hgrant_o), 32'h2);
    chk("burst_data_lag", 32'(bus.hmaster_data_o), 32'h2);
    tick();
    chk("burst_data_m1", 32'(bus.hmaster_data_o), 32'h1);

    // 4: WRAP8 on M3 terminated by IDLE after two SEQ
    drive(4'b1000, 4'b0000, IDLE, 3'd0, 1'b1);
    tick();
    chk("term_own_m3", 32'(bus.hmaster_o), 32'h3);
    drive(4'b0011, 4'b0000, NONSEQ, 3'd4, 1'b1);
    tick();
    drive(4'b0011, 4'b0000, SEQ, 3'd4, 1'b1);
    repeat (2) tick();
    chk("term_hold_m3", 32'(bus.hmaster_o), 32'h3);
    drive(4'b0011, 4'b0000, IDLE, 3'd4, 1'b1);
    tick();
    chk("term_grant_m0", 32'(bus.hgrant_o), 32'h1);

    // 5: locked sequence on M1 while everyone requests
    drive(4'b0010, 4'b0000, IDLE, 3'd0, 1'b1);
    tick();
    chk("lock_own_m1", 32'(bus.hmaster_o), 32'h1);
    drive(4'b1111, 4'b0010, NONSEQ, 3'd0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("lock_mastlock_%0d", k), 32'(bus.hmastlock_o), 32'h1);
      chk($sformatf("lock_grant_%0d", k),    32'(bus.hgrant_o), 32'h2);
    end
    drive(4'b1111, 4'b0000, IDLE, 3'd0, 1'b1);
    tick();
    chk("lock_release", 32'(bus.hmastlock_o), 32'h0);
    tick();
    chk("lock_rotate_m2", 32'(bus.hmaster_o), 32'h2);

    // 6: park with no requests, then reset in the middle of INCR16 on M2
    drive(4'b0000, 4'b0000, IDLE, 3'd0, 1'b1);
    tick();
    chk("park_grant", 32'(bus.hgrant_o), 32'h1);
    drive(4'b0100, 4'b0000, IDLE, 3'd0, 1'b1);
    tick();
    drive(4'b0100, 4'b0000, NONSEQ, 3'd7, 1'b1);
    tick();
    drive(4'b0100, 4'b0000, SEQ, 3'd7, 1'b1);
    repeat (3) tick();
    chk("incr16_hold_m2", 32'(bus.hmaster_o), 32'h2);
    hresetn = 1'b0;
    tick();
    chk("midreset_grant", 32'(bus.hgrant_o), 32'h1);
    chk("midreset_master", 32'(bus.hmaster_o), 32'h0);
    hresetn = 1'b1;
    // A leftover SEQ must not be taken as a burst continuation after reset.
    drive(4'b0010, 4'b0000, SEQ, 3'd7, 1'b1);
    tick();
    chk("postreset_arb_m1", 32'(bus.hmaster_o), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
